sound_mixer: RTL
================

SOUND_MIXER -- requirements
Module: sound_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of mono sources mixed (2..16).
REQ-002 SHALL have parameter SIG_WIDTH, default 16: signed width of each source and of each output channel.
REQ-003 SHALL have parameter VOL_WIDTH, default 8: unsigned per-source volume width; gain = VOL/128, so 128 is unity and 255 is about 1.99.
REQ-004 SHALL have port CLK  input  1  clock.
REQ-005 SHALL have port RESET_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port SAMPLE_REQ  input  1  single-cycle pulse that starts one mix pass.
REQ-007 SHALL have port IN_SIG  input  NUM_CH*SIG_WIDTH  signed sources; source k occupies slice k.
REQ-008 SHALL have port VOL_L  input  NUM_CH*VOL_WIDTH  left volume per source.
REQ-009 SHALL have port VOL_R  input  NUM_CH*VOL_WIDTH  right volume per source.
REQ-010 SHALL have port OUT_L  output  SIG_WIDTH  signed mixed left; it feeds the I2S DAC left input.
REQ-011 SHALL have port OUT_R  output  SIG_WIDTH  signed mixed right; it feeds the I2S DAC right input.
REQ-012 SHALL have port OUT_VALID  output  1  one-cycle pulse when OUT_L and OUT_R update.
REQ-013 SHALL have port BUSY  output  1  high while a mix pass is in progress.
REQ-014 SHALL have port OVERRUN  output  1  one-cycle pulse when SAMPLE_REQ arrives while BUSY.

Function
REQ-015 SHALL implement FSM states IDLE, MAC, SAT, DONE; after reset the state is IDLE.
REQ-016 SHALL move from IDLE to MAC on SAMPLE_REQ, latching IN_SIG, VOL_L and VOL_R into snapshot registers and clearing both accumulators in the same cycle.
REQ-017 SHALL, in MAC, use one shared signed-by-unsigned multiplier for 2*NUM_CH cycles in the order src0-L, src0-R, src1-L, ..., src(NUM_CH-1)-R.
REQ-018 SHALL, in MAC, add each product to the matching accumulator.
REQ-019 SHALL size each accumulator at SIG_WIDTH+VOL_WIDTH+clog2(NUM_CH)+1 bits, so no intermediate overflow occurs.
REQ-020 SHALL, after the last MAC cycle, enter SAT.
REQ-021 SHALL, in SAT, arithmetic-shift each accumulator right by 7 (floor rounding) and clamp it to [-2^(SIG_WIDTH-1), 2^(SIG_WIDTH-1)-1].
REQ-022 SHALL, in DONE, load OUT_L and OUT_R, pulse OUT_VALID for one cycle, and return to IDLE on the next cycle.
REQ-023 SHALL have latency such that SAMPLE_REQ sampled at edge 0 gives OUT_VALID high in the cycle after edge 2*NUM_CH+2 (edge 10 for NUM_CH=4).
REQ-024 SHALL drive BUSY high in every state other than IDLE.
REQ-025 SHALL hold OUT_L and OUT_R stable between OUT_VALID pulses.
REQ-026 SHALL ignore SAMPLE_REQ received in MAC, SAT or DONE, pulse OVERRUN in that cycle, and leave the pass in progress unaffected.
REQ-027 SHALL use only the snapshot values during a pass, so input changes during a pass do not affect its result.
REQ-028 SHALL accept a SAMPLE_REQ in the cycle after DONE, since the FSM is IDLE then.

Reset
REQ-029 SHALL, with RESET_n low, force state IDLE, OUT_L=0, OUT_R=0, OUT_VALID=0, BUSY=0, OVERRUN=0, accumulators 0 and snapshot registers 0.
REQ-030 SHALL, on reset asserted mid-pass, abandon the pass without any OUT_VALID pulse; the first SAMPLE_REQ after release starts a normal pass.

Structure
REQ-031 SHALL place the FSM state enum and the localparam GAIN_SHIFT=7 in the shared package sound_mixer_pkg.
REQ-032 SHALL implement the shift-and-clamp in one sub-module, sound_sat, instantiated once per output channel.

Verification (NUM_CH=4, SIG_WIDTH=16, VOL_WIDTH=8)
REQ-033 SHALL cover unity gain: src0=0x1000, VOL_L0=128, all other volumes 0, SAMPLE_REQ -> OUT_L=0x1000, OUT_R=0x0000, OUT_VALID 10 cycles after the request, BUSY high for 10 cycles.
REQ-034 SHALL cover cancellation: src0=0x4000 with VOL_L0=64, src1=0xE000 with VOL_L1=128 -> OUT_L=0x0000.
REQ-035 SHALL cover saturation: all sources 0x7000 at volume 255 -> OUT_L=OUT_R=0x7FFF; all sources 0x9000 at volume 255 -> 0x8000.
REQ-036 SHALL cover floor rounding: src0=0xFFFF, VOL_L0=64 -> OUT_L=0xFFFF (-1).
REQ-037 SHALL cover overrun: a second SAMPLE_REQ 3 cycles after the first -> OVERRUN pulses once, exactly one OUT_VALID, result equal to the first request's inputs.
REQ-038 SHALL cover reset mid-pass: RESET_n low at MAC cycle 4 -> no OUT_VALID, outputs 0, BUSY 0; a next request gives the correct result.

Source files
------------

// File: rtl/sound_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sound_mixer_pkg
// Brief   : Shared types and constants for the sound mixer (FSM states and
//           the fixed gain shift that makes VOL=128 unity).
// Revision: 1.0 - initial release
// ============================================================================
package sound_mixer_pkg;

  // Volume is a Q1.7 gain, so products are rescaled by 2^7.
  localparam int GAIN_SHIFT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAT  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sound_sat.sv
`default_nettype none
// ============================================================================
// Module  : sound_sat
// Brief   : Rescales a wide signed accumulator by an arithmetic right shift
//           (floor rounding) and clamps it to the signed output range.
// Revision: 1.0 - initial release
// ============================================================================
module sound_sat #(
  parameter int ACC_W = 27,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  // Shift then clamp; >>> on a signed operand rounds toward minus infinity.
  always_comb begin
    shifted = acc_i >>> SHIFT;
    if (shifted > MAX_V) begin
      sat_o = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      sat_o = MIN_V[OUT_W-1:0];
    end else begin
      sat_o = shifted[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sound_mixer.sv
`default_nettype none
// ============================================================================
// Module  : sound_mixer
// Brief   : Mixes NUM_CH mono sources into a stereo pair with per-source
//           left/right volume, using one shared multiplier over 2*NUM_CH
//           cycles, then saturates the result for the I2S DAC.
// Revision: 1.0 - initial release
// ============================================================================
module sound_mixer
  import sound_mixer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int SIG_WIDTH = 16,
  parameter int VOL_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic                          SAMPLE_REQ,
  input  logic [NUM_CH*SIG_WIDTH-1:0]   IN_SIG,
  input  logic [NUM_CH*VOL_WIDTH-1:0]   VOL_L,
  input  logic [NUM_CH*VOL_WIDTH-1:0]   VOL_R,
  output logic signed [SIG_WIDTH-1:0]   OUT_L,
  output logic signed [SIG_WIDTH-1:0]   OUT_R,
  output logic                          OUT_VALID,
  output logic                          BUSY,
  output logic                          OVERRUN
);

  localparam int ACC_W  = SIG_WIDTH + VOL_WIDTH + $clog2(NUM_CH) + 1;
  localparam int PROD_W = SIG_WIDTH + VOL_WIDTH + 1;
  localparam int IDX_W  = $clog2(2 * NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_CH - 1);

  state_t                        state_q;
  logic [NUM_CH*SIG_WIDTH-1:0]   sig_snap_q;
  logic [NUM_CH*VOL_WIDTH-1:0]   vol_l_snap_q;
  logic [NUM_CH*VOL_WIDTH-1:0]   vol_r_snap_q;
  logic [IDX_W-1:0]              idx_q;
  logic signed [ACC_W-1:0]       acc_l_q;
  logic signed [ACC_W-1:0]       acc_r_q;
  logic signed [SIG_WIDTH-1:0]   sat_l_q;
  logic signed [SIG_WIDTH-1:0]   sat_r_q;
  logic signed [SIG_WIDTH-1:0]   out_l_q;
  logic signed [SIG_WIDTH-1:0]   out_r_q;
  logic                          out_valid_q;

  logic [SIG_WIDTH-1:0]          mul_sig_d;
  logic [VOL_WIDTH-1:0]          mul_vol_d;
  logic signed [PROD_W-1:0]      mul_a_d;
  logic signed [PROD_W-1:0]      mul_b_d;
  logic signed [PROD_W-1:0]      prod_d;
  logic signed [ACC_W-1:0]       prod_ext_d;
  logic signed [SIG_WIDTH-1:0]   sat_l_d;
  logic signed [SIG_WIDTH-1:0]   sat_r_d;

  // Shared multiplier: even steps use the left volume, odd steps the right,
  // both against the same source (idx/2). Volume is zero-extended so it
  // multiplies as an unsigned gain.
  always_comb begin
    mul_sig_d  = sig_snap_q[int'(idx_q[IDX_W-1:1]) * SIG_WIDTH +: SIG_WIDTH];
    mul_vol_d  = idx_q[0] ? vol_r_snap_q[int'(idx_q[IDX_W-1:1]) * VOL_WIDTH +: VOL_WIDTH]
                          : vol_l_snap_q[int'(idx_q[IDX_W-1:1]) * VOL_WIDTH +: VOL_WIDTH];
    mul_a_d    = {{(VOL_WIDTH+1){mul_sig_d[SIG_WIDTH-1]}}, mul_sig_d};
    mul_b_d    = {{(SIG_WIDTH+1){1'b0}}, mul_vol_d};
    prod_d     = mul_a_d * mul_b_d;
    prod_ext_d = {{(ACC_W-PROD_W){prod_d[PROD_W-1]}}, prod_d};
  end

  sound_sat #(
    .ACC_W (ACC_W),
    .OUT_W (SIG_WIDTH),
    .SHIFT (GAIN_SHIFT)
  ) u_sat_l (
    .acc_i (acc_l_q),
    .sat_o (sat_l_d)
  );

  sound_sat #(
    .ACC_W (ACC_W),
    .OUT_W (SIG_WIDTH),
    .SHIFT (GAIN_SHIFT)
  ) u_sat_r (
    .acc_i (acc_r_q),
    .sat_o (sat_r_d)
  );

  // Mix-pass FSM: snapshot inputs, accumulate 2*NUM_CH products, saturate,
  // then publish the stereo pair with a one-cycle valid pulse.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= IDLE;
      sig_snap_q   <= '0;
      vol_l_snap_q <= '0;
      vol_r_snap_q <= '0;
      idx_q        <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      sat_l_q      <= '0;
      sat_r_q      <= '0;
      out_l_q      <= '0;
      out_r_q      <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SAMPLE_REQ) begin
            sig_snap_q   <= IN_SIG;
            vol_l_snap_q <= VOL_L;
            vol_r_snap_q <= VOL_R;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            idx_q        <= '0;
            state_q      <= MAC;
          end
        end
        MAC: begin
          if (idx_q[0]) begin
            acc_r_q <= acc_r_q + prod_ext_d;
          end else begin
            acc_l_q <= acc_l_q + prod_ext_d;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= SAT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SAT: begin
          sat_l_q <= sat_l_d;
          sat_r_q <= sat_r_d;
          state_q <= DONE;
        end
        DONE: begin
          out_l_q     <= sat_l_q;
          out_r_q     <= sat_r_q;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign OUT_L     = out_l_q;
  assign OUT_R     = out_r_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = (state_q != IDLE);
  // A request while a pass runs is dropped; flag it in the same cycle.
  assign OVERRUN   = SAMPLE_REQ && (state_q != IDLE);

endmodule
`default_nettype wire
